output_serializer: RTL and testbench

OUTPUT_SERIALIZER -- requirements
Module: output_serializer

---
 rtl/bsnce_pkg.sv | 16 +
 rtl/output_serializer.sv | 102 ++++++++++
 tb/tb_output_serializer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsnce_pkg.sv
// Shared definitions for the result-vector serializer and its input-side buffer.
package bsnce_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int unsigned BSNCE_DATA_W = 16;

  // Read-pointer width; a single-element vector still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/output_serializer.sv
// Captures a packed result vector and streams its elements out one per beat.
module output_serializer
  import bsnce_pkg::*;
#(
  parameter int unsigned DATA_W       = BSNCE_DATA_W,
  parameter int unsigned N_OUT        = 32,
  parameter bit          REPORT_DROPS = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic signed [N_OUT*DATA_W-1:0]  result_bus,
  input  logic                            result_valid,
  output logic                            busy,
  output logic signed [DATA_W-1:0]        m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic [7:0]                      drop_cnt
);

  localparam int unsigned         PTR_W    = ptr_width(N_OUT);
  localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(N_OUT - 1);

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  vec_q [N_OUT];
  logic [PTR_W-1:0]   rd_ptr;
  logic               xfer;
  logic               last_xfer;
  logic               capture;
  logic               drop;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, stream handshake outputs and capture/drop decisions.
  always_comb begin
    state_nxt = state;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (result_valid) begin
          capture   = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        m_tvalid  = 1'b1;
        m_tlast   = (rd_ptr == LAST_PTR);
        xfer      = m_tready;
        last_xfer = m_tready && (rd_ptr == LAST_PTR);
        if (last_xfer) begin
          // A vector arriving on the final transfer is taken with no bubble.
          if (result_valid) capture   = 1'b1;
          else              state_nxt = IDLE;
        end else if (result_valid) begin
          drop = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Vector storage, read pointer and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_OUT; k++) vec_q[k] <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      if (capture) begin
        for (int unsigned k = 0; k < N_OUT; k++)
          vec_q[k] <= result_bus[k*DATA_W +: DATA_W];
        rd_ptr <= '0;
      end else if (xfer && !last_xfer) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Data is a plain indexed read; in IDLE the pointer rests on the last
  // element so the final beat's value stays on the bus.
  assign m_tdata = vec_q[rd_ptr];
  assign busy    = (state == STREAM);

`ifndef SYNTHESIS
  // Flag each vector lost because the stream was still busy.
  always_ff @(posedge clk) begin
    if (REPORT_DROPS && rst_n && drop)
      $error("output_serializer: result vector dropped while busy");
  end
`endif

endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer with a queue-based reference model.
module tb_output_serializer;

  localparam int unsigned DW = 16;
  localparam int unsigned NO = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic signed [NO*DW-1:0] result_bus;
  logic                    result_valid;
  logic                    busy;
  logic signed [DW-1:0]    m_tdata;
  logic                    m_tvalid;
  logic                    m_tready;
  logic                    m_tlast;
  logic [7:0]              drop_cnt;

  // Single-element build
  logic signed [DW-1:0]    result_bus1;
  logic                    result_valid1;
  logic                    busy1;
  logic signed [DW-1:0]    m_tdata1;
  logic                    m_tvalid1;
  logic                    m_tready1;
  logic                    m_tlast1;
  logic [7:0]              drop_cnt1;

  always #5 clk = ~clk;

  output_serializer #(.DATA_W(DW), .N_OUT(NO), .REPORT_DROPS(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .result_bus(result_bus), .result_valid(result_valid),
    .busy(busy), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .drop_cnt(drop_cnt)
  );

  output_serializer #(.DATA_W(DW), .N_OUT(1), .REPORT_DROPS(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .result_bus(result_bus1), .result_valid(result_valid1),
    .busy(busy1), .m_tdata(m_tdata1), .m_tvalid(m_tvalid1), .m_tready(m_tready1),
    .m_tlast(m_tlast1), .drop_cnt(drop_cnt1)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned xfers = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] data;
    bit          last;
  } beat_t;

  beat_t       q[$];
  logic [15:0] idle_data = '0;
  int unsigned m_drop = 0;

  always @(posedge clk) begin
    bit take, xf, lx;
    if (!rst_n) begin
      q.delete();
      idle_data = '0;
      m_drop    = 0;
    end else begin
      xf   = (q.size() != 0) && m_tready;
      lx   = xf && q[0].last;
      take = 1'b0;
      if (result_valid) begin
        if (q.size() == 0 || lx) take = 1'b1;
        else if (m_drop < 255) m_drop++;
      end
      if (xf) begin
        idle_data = q[0].data;
        void'(q.pop_front());
      end
      if (take)
        for (int k = 0; k < NO; k++)
          q.push_back('{data: result_bus[k*DW +: DW], last: (k == NO-1)});
    end
  end

  // Compare DUT against the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    logic        ev;
    logic [15:0] ed;
    logic        el;
    if (chk_en) begin
      ev = (q.size() != 0);
      ed = ev ? q[0].data : idle_data;
      el = ev ? q[0].last : 1'b0;
      check("tvalid", {15'd0, m_tvalid}, {15'd0, ev});
      check("busy",   {15'd0, busy},     {15'd0, ev});
      check("tlast",  {15'd0, m_tlast},  {15'd0, el});
      check("tdata",  m_tdata,           ed);
      check("drop_cnt", {8'd0, drop_cnt}, 16'(m_drop));
      if (m_tvalid && m_tready) xfers++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  logic [NO*DW-1:0] vec1, vec2;
  logic [15:0]      exp1 [NO];
  int unsigned      x0;

  initial begin
    vec1 = {16'h7FFF, 16'h0003, 16'hFFFE, 16'h0001};
    vec2 = {16'h0040, 16'h8001, 16'h1234, 16'hA5A5};
    exp1 = '{16'h0001, 16'hFFFE, 16'h0003, 16'h7FFF};
    rst_n = 1'b0; result_valid = 1'b0; result_bus = '0; m_tready = 1'b1;
    result_valid1 = 1'b0; result_bus1 = '0; m_tready1 = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    at_neg();
    check("rst_tvalid", {15'd0, m_tvalid}, 16'd0);
    check("rst_busy",   {15'd0, busy},     16'd0);
    check("rst_tdata",  m_tdata,           16'h0000);
    check("rst_drop",   {8'd0, drop_cnt},  16'd0);
    check("rst1_busy",  {15'd0, busy1},    16'd0);

    // Basic vector, ready always high
    result_bus = vec1; result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    for (int k = 0; k < NO; k++) begin
      at_neg();
      check("basic_data", m_tdata, exp1[k]);
      check("basic_last", {15'd0, m_tlast}, {15'd0, k == NO-1});
      check("basic_busy", {15'd0, busy}, 16'd1);
      tick();
    end
    at_neg();
    check("basic_idle_valid", {15'd0, m_tvalid}, 16'd0);
    check("basic_idle_hold",  m_tdata, 16'h7FFF);

    // Backpressure on stream cycles 2-3
    tick();
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    x0 = xfers;
    tick();
    m_tready = 1'b0;
    at_neg();
    check("stall_c2", m_tdata, 16'hFFFE);
    tick();
    at_neg();
    check("stall_c3", m_tdata, 16'hFFFE);
    check("stall_c3_last", {15'd0, m_tlast}, 16'd0);
    tick();
    m_tready = 1'b1;
    at_neg();
    check("stall_c4", m_tdata, 16'hFFFE);
    tick(); tick(); tick();
    at_neg();
    check("stall_idle", {15'd0, m_tvalid}, 16'd0);
    check("stall_beats", 16'(xfers - x0), 16'd4);

    // Zero-bubble back-to-back vectors
    tick();
    result_bus = vec1; result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    tick(); tick(); tick();
    result_bus = vec2; result_valid = 1'b1;
    at_neg();
    check("b2b_last", {15'd0, m_tlast}, 16'd1);
    tick();
    result_valid = 1'b0;
    at_neg();
    check("b2b_valid", {15'd0, m_tvalid}, 16'd1);
    check("b2b_data",  m_tdata, 16'hA5A5);
    check("b2b_drop",  {8'd0, drop_cnt}, 16'd0);
    tick(); tick(); tick(); tick();
    at_neg();
    check("b2b_idle", {15'd0, busy}, 16'd0);

    // Drop while beat 2 pending
    tick();
    result_bus = vec1; result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    tick();
    result_bus = vec2; result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    at_neg();
    check("drop_one", {8'd0, drop_cnt}, 16'd1);
    check("drop_stream", m_tdata, 16'h0003);
    tick(); tick();
    at_neg();
    check("drop_idle", {15'd0, m_tvalid}, 16'd0);

    // Saturation: stall a stream and keep pulsing
    result_bus = vec1; result_valid = 1'b1; m_tready = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) tick();
    result_valid = 1'b0;
    at_neg();
    check("drop_sat", {8'd0, drop_cnt}, 16'd255);
    check("drop_sat_data", m_tdata, 16'h0001);
    m_tready = 1'b1;
    tick(); tick(); tick(); tick();
    at_neg();
    check("sat_idle", {15'd0, busy}, 16'd0);

    // Reset during beat 3
    result_bus = vec1; result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    tick(); tick();
    at_neg();
    check("rst_mid_beat3", m_tdata, 16'h0003);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    at_neg();
    check("rst_mid_valid", {15'd0, m_tvalid}, 16'd0);
    check("rst_mid_busy",  {15'd0, busy}, 16'd0);
    check("rst_mid_drop",  {8'd0, drop_cnt}, 16'd0);
    tick();
    at_neg();
    check("rst_mid_quiet", {15'd0, m_tvalid}, 16'd0);
    result_bus = vec2; result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    at_neg();
    check("rst_new_data", m_tdata, 16'hA5A5);
    tick(); tick(); tick(); tick();
    at_neg();
    check("rst_new_hold", m_tdata, 16'h0040);

    // Single-element build
    result_bus1 = 16'h8000; result_valid1 = 1'b1;
    tick();
    result_valid1 = 1'b0;
    at_neg();
    check("n1_valid", {15'd0, m_tvalid1}, 16'd1);
    check("n1_data",  m_tdata1, 16'h8000);
    check("n1_last",  {15'd0, m_tlast1}, 16'd1);
    check("n1_busy",  {15'd0, busy1}, 16'd1);
    tick();
    at_neg();
    check("n1_idle_valid", {15'd0, m_tvalid1}, 16'd0);
    check("n1_idle_last",  {15'd0, m_tlast1}, 16'd0);
    check("n1_idle_hold",  m_tdata1, 16'h8000);
    check("n1_drop",       {8'd0, drop_cnt1}, 16'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
